// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if
//   Bundles the two buses the stream reader sits between:
//   - RAM port: mem_wr, mem_addr, mem_wdata (reader -> RAM), mem_rdata (RAM -> reader)
//   - Output stream: out_valid, out_data, out_last (reader -> sink), out_ready (sink -> reader)
//   master: the reader side (drives RAM control and the stream)
//   slave : the environment side (RAM plus downstream sink)
interface ram_stream_reader_if #(
    parameter int MEM_SIZE  = 512,
    parameter int MEM_WIDTH = 8
);
    localparam int AW = $clog2(MEM_SIZE);

    logic                 mem_wr;
    logic [AW-1:0]        mem_addr;
    logic [MEM_WIDTH-1:0] mem_wdata;
    logic [MEM_WIDTH-1:0] mem_rdata;

    logic                 out_valid;
    logic                 out_ready;
    logic [MEM_WIDTH-1:0] out_data;
    logic                 out_last;

    modport master (
        output mem_wr, mem_addr, mem_wdata,
        input  mem_rdata,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_wr, mem_addr, mem_wdata,
        output mem_rdata,
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Walks an address range of a single-port synchronous RAM (1-cycle read
//   latency) and presents the words as a valid/ready stream. A host write
//   path shares the RAM port and always wins over reads.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   start, stop, loop       run control (start/stop are pulses, loop sampled with start)
//   start_addr, end_addr    inclusive range, sampled with start, wraps modulo MEM_SIZE
//   host_wr/addr/wdata      host write into the RAM
//   bus (master)            RAM port and output stream
//   busy                    a run is active
//   done                    pulses during the cycle the last word of a non-loop run is accepted
//
// state  | meaning
// S_IDLE | no run active, no reads issued, FIFO empty
// S_RUN  | issuing reads over the range and streaming them out
module ram_stream_reader #(
    parameter  int MEM_SIZE  = 512,
    parameter  int MEM_WIDTH = 8,
    localparam int AW        = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    input  logic [AW-1:0]        start_addr,
    input  logic [AW-1:0]        end_addr,
    input  logic                 host_wr,
    input  logic [AW-1:0]        host_addr,
    input  logic [MEM_WIDTH-1:0] host_wdata,
    ram_stream_reader_if.master  bus,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t               state, state_nx;
    logic [AW-1:0]        sa_r, ea_r, rp, rp_inc;
    logic                 loop_r;
    logic                 range_done;
    logic                 rd_pend, rd_last_pend;
    logic [MEM_WIDTH-1:0] fifo_data [2];
    logic [1:0]           fifo_last;
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           fifo_count;
    logic [2:0]           occ;
    logic                 pop, push, issue, launch, finish, rp_at_end;

    assign pop       = bus.out_valid && bus.out_ready;
    assign push      = rd_pend;
    assign rp_at_end = (rp == ea_r);
    assign rp_inc    = (rp == AW'(MEM_SIZE - 1)) ? '0 : rp + AW'(1);

    // Words held plus the one in flight; a new read may only go out if the
    // FIFO is guaranteed room for it after this cycle's pop.
    assign occ = {1'b0, fifo_count} + {2'b00, rd_pend};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        issue    = 1'b0;
        finish   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nx = S_RUN;
                    launch   = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_nx = S_IDLE;
                end else begin
                    if (!host_wr && !range_done && (occ < (3'd2 + {2'b00, pop}))) begin
                        issue = 1'b1;
                    end
                    // Everything issued and captured: a single remaining word is the last one.
                    if (range_done && !rd_pend && (fifo_count == 2'd1) && pop) begin
                        finish   = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = finish;

    // Host write always owns the port; otherwise the port points at rp.
    assign bus.mem_wr    = host_wr;
    assign bus.mem_wdata = host_wdata;
    assign bus.mem_addr  = host_wr ? host_addr : rp;

    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
    assign bus.out_last  = bus.out_valid & fifo_last[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa_r         <= '0;
            ea_r         <= '0;
            loop_r       <= 1'b0;
            rp           <= '0;
            range_done   <= 1'b0;
            rd_pend      <= 1'b0;
            rd_last_pend <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_count   <= '0;
        end else begin
            if (launch) begin
                sa_r       <= start_addr;
                ea_r       <= end_addr;
                loop_r     <= loop;
                rp         <= start_addr;
                range_done <= 1'b0;
            end else if (issue) begin
                if (rp_at_end) begin
                    if (loop_r) begin
                        rp <= sa_r;
                    end else begin
                        range_done <= 1'b1;
                    end
                end else begin
                    rp <= rp_inc;
                end
            end

            // Never set after a host write cycle, so echoed write data is not captured.
            rd_pend      <= issue;
            rd_last_pend <= issue && rp_at_end;

            if ((state == S_RUN) && stop) begin
                wr_ptr     <= 1'b0;
                rd_ptr     <= 1'b0;
                fifo_count <= '0;
            end else begin
                if (push) begin
                    fifo_data[wr_ptr] <= bus.mem_rdata;
                    fifo_last[wr_ptr] <= rd_last_pend;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + 2'd1;
                    2'b01:   fifo_count <= fifo_count - 2'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader
//   Directed bench for ram_stream_reader with a behavioural 512x8 RAM
//   (mem[i]=i preloaded, 1-cycle registered read, write data echoed on reads).
//   Inputs change on the falling edge; outputs are sampled 1-2 time units later.
module tb_ram_stream_reader;

    logic       clk;
    logic       reset_n;
    logic       start, stop, loop;
    logic [8:0] start_addr, end_addr, host_addr;
    logic       host_wr;
    logic [7:0] host_wdata;
    logic       busy, done;

    int total = 0;
    int bad   = 0;

    ram_stream_reader_if #(.MEM_SIZE(512), .MEM_WIDTH(8)) bus ();

    ram_stream_reader #(.MEM_SIZE(512), .MEM_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [512];
    logic       ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 512; i++) ram[i] <= 8'(i);
            ram_loaded <= 1'b1;
        end else if (bus.mem_wr) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata     <= bus.mem_wdata;
        end else begin
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // Accepted words {last, data} and done pulses, recorded in the cycle they happen.
    logic [8:0] acc_q [$];
    int         done_cnt = 0;

    always begin
        @(negedge clk);
        #2;
        if (reset_n && bus.out_valid && bus.out_ready) acc_q.push_back({bus.out_last, bus.out_data});
        if (reset_n && done) done_cnt++;
    end

    task automatic run_start(input logic [8:0] sa, input logic [8:0] ea, input logic lp);
        @(negedge clk);
        start = 1'b1; start_addr = sa; end_addr = ea; loop = lp;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", bus.out_data); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b expected 0", bus.out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [4] = '{8'd4, 8'd5, 8'd6, 8'd7};
        logic [8:0] got;
        int q0 = acc_q.size();
        int d0 = done_cnt;
        int n  = 0;
        bus.out_ready = 1'b1;
        run_start(9'd4, 9'd7, 1'b0);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b expected 1", busy); end
        total++; if (bus.mem_addr !== 9'd4) begin bad++; $display("FAIL basic_first_addr: got %0d expected 4", bus.mem_addr); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_e1: got %b expected 0", bus.out_valid); end
        @(negedge clk); #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_e2: got %b expected 0", bus.out_valid); end
        @(negedge clk); #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd4) begin bad++; $display("FAIL basic_first_word: valid=%b data=%h expected 1/04", bus.out_valid, bus.out_data); end
        while (busy && n < 100) begin @(negedge clk); #1; n++; end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: busy=%b expected 0", busy); end
        total++; if (acc_q.size() - q0 != 4) begin bad++; $display("FAIL basic_count: got %0d expected 4", acc_q.size() - q0); end
        for (int k = 0; k < 4; k++) begin
            got = (q0 + k < acc_q.size()) ? acc_q[q0 + k] : 9'bx;
            total++;
            if (got !== {(k == 3), exp_d[k]}) begin
                bad++; $display("FAIL basic_word[%0d]: got last=%b data=%h expected last=%b data=%h", k, got[8], got[7:0], (k == 3), exp_d[k]);
            end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done: pulses=%0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_d [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic [8:0] got;
        int q0 = acc_q.size();
        int n  = 0;
        bus.out_ready = 1'b1;
        run_start(9'd510, 9'd1, 1'b0);
        while (busy && n < 100) begin @(negedge clk); #1; n++; end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_idle: busy=%b expected 0", busy); end
        total++; if (acc_q.size() - q0 != 4) begin bad++; $display("FAIL wrap_count: got %0d expected 4", acc_q.size() - q0); end
        for (int k = 0; k < 4; k++) begin
            got = (q0 + k < acc_q.size()) ? acc_q[q0 + k] : 9'bx;
            total++;
            if (got !== {(k == 3), exp_d[k]}) begin
                bad++; $display("FAIL wrap_word[%0d]: got last=%b data=%h expected last=%b data=%h", k, got[8], got[7:0], (k == 3), exp_d[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] got;
        logic [7:0] pd;
        logic       pl;
        logic       prev_stall = 1'b0;
        int         stall_bad = 0;
        int         stalls = 0;
        int         q0 = acc_q.size();
        bus.out_ready = 1'b0;
        run_start(9'd0, 9'd15, 1'b0);
        for (int c = 0; c < 300 && busy; c++) begin
            bus.out_ready = ((c % 3) == 0);
            #1;
            if (prev_stall && (!bus.out_valid || bus.out_data !== pd || bus.out_last !== pl)) stall_bad++;
            prev_stall = bus.out_valid && !bus.out_ready;
            pd = bus.out_data;
            pl = bus.out_last;
            if (prev_stall) stalls++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle: busy=%b expected 0", busy); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stable: %0d unstable stall cycles, expected 0", stall_bad); end
        total++; if (stalls == 0) begin bad++; $display("FAIL bp_stalled: %0d stall cycles, expected some", stalls); end
        total++; if (acc_q.size() - q0 != 16) begin bad++; $display("FAIL bp_count: got %0d expected 16", acc_q.size() - q0); end
        for (int k = 0; k < 16; k++) begin
            got = (q0 + k < acc_q.size()) ? acc_q[q0 + k] : 9'bx;
            total++;
            if (got !== {(k == 15), 8'(k)}) begin
                bad++; $display("FAIL bp_word[%0d]: got last=%b data=%h expected last=%b data=%h", k, got[8], got[7:0], (k == 15), 8'(k));
            end
        end
    endtask

    task automatic test_host_write();
        logic [8:0] got;
        logic [7:0] e;
        int q0 = acc_q.size();
        int n  = 0;
        bus.out_ready = 1'b1;
        run_start(9'd0, 9'd15, 1'b0);
        host_wr = 1'b1; host_addr = 9'd10; host_wdata = 8'hAA;
        #1;
        total++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 9'd10 || bus.mem_wdata !== 8'hAA) begin
            bad++; $display("FAIL host_priority: wr=%b addr=%0d wdata=%h expected 1/10/aa", bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        host_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        host_wr = 1'b1; host_addr = 9'd200; host_wdata = 8'h55;
        @(negedge clk);
        host_wr = 1'b0;
        #1;
        while (busy && n < 100) begin @(negedge clk); #1; n++; end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL host_idle: busy=%b expected 0", busy); end
        total++; if (acc_q.size() - q0 != 16) begin bad++; $display("FAIL host_count: got %0d expected 16", acc_q.size() - q0); end
        for (int k = 0; k < 16; k++) begin
            e   = (k == 10) ? 8'hAA : 8'(k);
            got = (q0 + k < acc_q.size()) ? acc_q[q0 + k] : 9'bx;
            total++;
            if (got !== {(k == 15), e}) begin
                bad++; $display("FAIL host_word[%0d]: got last=%b data=%h expected last=%b data=%h", k, got[8], got[7:0], (k == 15), e);
            end
        end
        total++; if (ram[200] !== 8'h55) begin bad++; $display("FAIL host_ram200: got %h expected 55", ram[200]); end
    endtask

    task automatic test_loop_stop();
        logic [7:0] exp_d [5] = '{8'd2, 8'd3, 8'd2, 8'd3, 8'd2};
        logic [8:0] got;
        int q0  = acc_q.size();
        int d0  = done_cnt;
        int acc = 0;
        bus.out_ready = 1'b1;
        run_start(9'd2, 9'd3, 1'b1);
        for (int c = 0; c < 60 && acc < 5; c++) begin
            #1;
            if (bus.out_valid && bus.out_ready) begin
                acc++;
                if (acc == 5) stop = 1'b1;
            end
            @(negedge clk);
        end
        stop = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL loop_valid_after_stop: got %b expected 0", bus.out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL loop_busy_after_stop: got %b expected 0", busy); end
        repeat (4) @(negedge clk);
        #1;
        total++; if (acc_q.size() - q0 != 5) begin bad++; $display("FAIL loop_count: got %0d expected 5", acc_q.size() - q0); end
        for (int k = 0; k < 5; k++) begin
            got = (q0 + k < acc_q.size()) ? acc_q[q0 + k] : 9'bx;
            total++;
            if (got !== {exp_d[k] == 8'd3, exp_d[k]}) begin
                bad++; $display("FAIL loop_word[%0d]: got last=%b data=%h expected last=%b data=%h", k, got[8], got[7:0], exp_d[k] == 8'd3, exp_d[k]);
            end
        end
        total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL loop_done: pulses=%0d expected 0", done_cnt - d0); end
    endtask

    task automatic test_async_reset();
        logic [8:0] got;
        int q0, d0;
        int n = 0;
        bus.out_ready = 1'b0;
        run_start(9'd20, 9'd40, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd20) begin
            bad++; $display("FAIL areset_pre: valid=%b data=%h expected 1/14", bus.out_valid, bus.out_data);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b expected 0", bus.out_valid); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL areset_data: got %h expected 00", bus.out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b expected 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        q0 = acc_q.size();
        d0 = done_cnt;
        run_start(9'd30, 9'd32, 1'b0);
        while (busy && n < 100) begin @(negedge clk); #1; n++; end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_idle: busy=%b expected 0", busy); end
        total++; if (acc_q.size() - q0 != 3) begin bad++; $display("FAIL areset_count: got %0d expected 3", acc_q.size() - q0); end
        for (int k = 0; k < 3; k++) begin
            got = (q0 + k < acc_q.size()) ? acc_q[q0 + k] : 9'bx;
            total++;
            if (got !== {(k == 2), 8'(30 + k)}) begin
                bad++; $display("FAIL areset_word[%0d]: got last=%b data=%h expected last=%b data=%h", k, got[8], got[7:0], (k == 2), 8'(30 + k));
            end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL areset_done: pulses=%0d expected 1", done_cnt - d0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        loop          = 1'b0;
        start_addr    = '0;
        end_addr      = '0;
        host_wr       = 1'b0;
        host_addr     = '0;
        host_wdata    = '0;
        bus.out_ready = 1'b0;

        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_host_write();
        test_loop_stop();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Sequencer sitting directly in front of the team's single-port synchronous RAM (512x8, 1-cycle registered read; on a write cycle the read data returns the write data).
- Drives the RAM address and control, walks an address range, and presents the words as a valid/ready stream to downstream logic.
- Also provides a host write path into the same RAM port, for runtime content updates.

Parameters:
MEM_SIZE, 512, RAM depth in words; address width AW = $clog2(MEM_SIZE)
MEM_WIDTH, 8, RAM word width in bits

Ports:
clk  in  1  single clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  pulse; begins a run when IDLE
stop  in  1  pulse; aborts run or loop
loop  in  1  sampled with start; 1 = repeat the range until stop
start_addr  in  AW  first address, sampled with start
end_addr  in  AW  last address (inclusive), sampled with start
host_wr  in  1  host write request, 1 cycle per word
host_addr  in  AW  host write address
host_wdata  in  MEM_WIDTH  host write data
mem_wr  out  1  to RAM write enable (combinational: = host_wr)
mem_addr  out  AW  to RAM address (combinational mux)
mem_wdata  out  MEM_WIDTH  to RAM write data (= host_wdata)
mem_rdata  in  MEM_WIDTH  from RAM read data
out_valid  out  1  stream data valid
out_ready  in  1  downstream accepts
out_data  out  MEM_WIDTH  stream word
out_last  out  1  word came from end_addr
busy  out  1  state != IDLE
done  out  1  1-cycle pulse on acceptance of the last word of a non-loop run

Behaviour:
- Reset (async, reset_n=0): state IDLE, FIFO empty, rd_pend=0; out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- States: IDLE, RUN, FLUSH-free abort (stop returns directly to IDLE).
- IDLE -> RUN: start=1 && stop=0.
  - Latch start_addr, end_addr, loop.
  - Read pointer rp = start_addr.
  - start while busy is ignored. start && stop together in IDLE: stays IDLE.
- Read issue:
  - At most one read per cycle, only when all of the following hold:
    - state is RUN;
    - host_wr=0;
    - the range is not exhausted;
    - fifo_count + rd_pend - pop < 2, where pop = out_valid && out_ready.
  - On issue: mem_addr = rp, and rd_pend is set for the next cycle.
  - When no read is issued: mem_addr = host_wr ? host_addr : rp.
- Capture: the cycle after an issue, mem_rdata is pushed into the 2-entry output FIFO, together with the last flag for that address. Captured data is never dropped.
- Host write:
  - Has priority over reads and is legal in any state.
  - rd_pend stays 0 for the cycle after a write, so the echoed write data is never captured.
- Address arithmetic:
  - rp advances by 1 modulo MEM_SIZE (MEM_SIZE-1 wraps to 0).
  - Run length = ((end_addr - start_addr) mod MEM_SIZE) + 1. start_addr == end_addr gives one word.
- End of range, after issuing end_addr:
  - loop=1: rp reloads start_addr and issuing continues.
  - loop=0: issuing stops. State returns to IDLE when the FIFO is empty, rd_pend=0, and the last word has been accepted; done pulses in that same cycle.
- Latency: start sampled at edge E0; read issued in the cycle after E0; out_valid=1 after edge E2.
- Throughput: 1 word/cycle with out_ready held at 1 and no host writes.
- Backpressure: out_data and out_last are held stable while out_valid=1 and out_ready=0.
- stop in RUN:
  - Next edge: FIFO cleared, rd_pend cleared, out_valid=0, state IDLE, no done.
  - A stop and a host_wr in the same cycle: the write still completes.
- out_last is 1 exactly on the word read from end_addr, including every loop pass.

Test Plan:
- RAM preloaded mem[i]=i. start, start_addr=4, end_addr=7, loop=0, out_ready=1 -> words 4,5,6,7; out_valid first high after the 2nd edge following start; out_last only on 7; done pulses once; then busy=0.
- Wrap: start_addr=510, end_addr=1 -> words 0xFE,0xFF,0x00,0x01; out_last on 0x01.
- Backpressure: out_ready toggling 1,0,0,1,... over range 0..15 -> all 16 words delivered in order, no duplicates; out_data stable during stalls; at most 2 reads outstanding.
- Host interference: during the 0..15 run, host_wr to address 10 with 0xAA, issued before rp reaches 10 -> stream shows 0xAA at position 10; host writes cause no spurious words.
- loop=1 over range 2..3, stop after 5 accepted words -> stream 2,3,2,3,2; out_valid=0 on the edge after stop; busy=0; done never pulses.
- reset_n=0 mid-run -> outputs 0 immediately (asynchronously); a new start afterwards runs cleanly from its start_addr.
